data_sw_sched: RTL

Round-robin scheduler that shares the original/complement code-switch datapath between two requesters (A, B). Each requester asks for the datapath in one mode (original or complement) for a burst of cycles. The block drives the datapath's `sw` select and waits a settle interval so the registered datapath output reflects the new mode. It then flags the cycles in which `data_out` is valid for the current owner. It sits between the requesting blocks and the code-switch register stage, on the same clock.

---
 rtl/data_sw_sched.sv | 98 +++++++++
 1 files changed

// File: rtl/data_sw_sched.sv
// Round-robin scheduler sharing the original/complement code-switch datapath
// between requesters A and B. Optional feature: DATA_SW_SAME_MODE_BYPASS_EN.
module data_sw_sched #(
  parameter int SETTLE = 2,
  parameter int LEN_W  = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic             req_a,
  input  logic             mode_a,
  input  logic [LEN_W-1:0] len_a,
  input  logic             req_b,
  input  logic             mode_b,
  input  logic [LEN_W-1:0] len_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sw,
  output logic             owner,
  output logic             busy,
  output logic             data_vld,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SWITCH, RUN} state_t;

  state_t           state, state_d;
  logic [3:0]       settle_cnt;
  logic [LEN_W-1:0] run_cnt;
  logic             last_owner;

  logic             grant;
  logic             win;
  logic             win_mode;
  logic [LEN_W-1:0] win_len;

  // Arbitration and next state. A tie goes to whoever did not own last.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    state_d  = state;
    grant    = (state == IDLE) && (req_a || req_b);
    win      = (req_a && req_b) ? ~last_owner : req_b;
    win_mode = win ? mode_b : mode_a;
    win_len  = win ? len_b : len_a;
    case (state)
      IDLE: if (grant) begin
`ifdef DATA_SW_SAME_MODE_BYPASS_EN
        state_d = (win_mode == sw) ? RUN : SWITCH;
`else
        state_d = SWITCH;
`endif
      end
      SWITCH:  if (settle_cnt == 4'd0) state_d = RUN;
      RUN:     if (run_cnt == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is assigned with <= so all flops update together.
    if (res) state <= IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      sw         <= 1'b0;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      gnt_a      <= 1'b0;
      gnt_b      <= 1'b0;
      settle_cnt <= 4'd0;
      run_cnt    <= '0;
    end else begin
      gnt_a <= grant && !win;
      gnt_b <= grant && win;
      if (grant) begin
        sw         <= win_mode;
        owner      <= win;
        run_cnt    <= win_len;
        settle_cnt <= 4'(SETTLE - 1);
      end else begin
        if (state == SWITCH && settle_cnt != 4'd0)
          settle_cnt <= settle_cnt - 4'd1;
        // last_owner only moves on a completed burst, so an aborted one leaves it alone.
        if (state == RUN) begin
          if (run_cnt != '0) run_cnt    <= run_cnt - LEN_W'(1);
          else               last_owner <= owner;
        end
      end
    end
  end

  // Status flags are pure decodes of the state and counter flops.
  assign busy     = (state != IDLE);
  assign data_vld = (state == RUN);
  assign done     = (state == RUN) && (run_cnt == '0);

endmodule
